// File: rtl/tdm_serial_in.sv
// TDM serial PCM receiver: frames bytes from sdi on bit_en strobes, tags
// them with a channel number and queues them in a small FIFO.
// Ports:
//   clk, reset (async, active-high)
//   bit_en, fs, sdi              serial TDM input, qualified by bit_en
//   out_ready                    downstream accepts the head sample
//   err_clr                      clears the sticky error flags
//   out_valid, out_data, out_ch  FIFO head sample
//   fifo_cnt                     FIFO occupancy
//   ovf, frm_err                 sticky error flags
module tdm_serial_in #(
  parameter int NUM_CH     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          bit_en,
  input  logic                          fs,
  input  logic                          sdi,
  input  logic                          out_ready,
  input  logic                          err_clr,
  output logic                          out_valid,
  output logic [7:0]                    out_data,
  output logic [4:0]                    out_ch,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          ovf,
  output logic                          frm_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    UNSYNC = 1'b0,
    SYNC   = 1'b1
  } st_t;

  st_t st, st_n;

  logic [7:0]  sh;
  logic [2:0]  bidx;
  logic [4:0]  ch;

  logic        resync;
  logic        misfs;
  logic        shift;
  logic        push;
  logic [7:0]  byte_n;

  logic [12:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr, rptr_n;
  logic [CW-1:0] cnt, rem;
  logic [12:0] head;
  logic        full, pop, wr, drop;

  // ---- framing FSM ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= UNSYNC;
    else       st <= st_n;
  end

  always_comb begin
    st_n = st;
    if (bit_en && fs) st_n = SYNC;
  end

  always_comb begin
    resync = 1'b0;
    misfs  = 1'b0;
    shift  = 1'b0;
    push   = 1'b0;
    byte_n = {sh[6:0], sdi};
    if (bit_en && fs) begin
      resync = 1'b1;
      // fs is only legal at the start of channel 0 once locked
      misfs  = (st == SYNC) && ((bidx != 3'd0) || (ch != 5'd0));
    end else if (bit_en && st == SYNC) begin
      shift = 1'b1;
      push  = (bidx == 3'd7);
    end
  end

  // ---- shifter, bit index, channel ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh   <= '0;
      bidx <= '0;
      ch   <= '0;
    end else if (resync) begin
      sh   <= {7'd0, sdi};
      bidx <= 3'd1;
      ch   <= '0;
    end else if (shift) begin
      sh <= byte_n;
      if (bidx == 3'd7) begin
        bidx <= '0;
        ch   <= (ch == 5'(NUM_CH - 1)) ? 5'd0 : ch + 5'd1;
      end else begin
        bidx <= bidx + 3'd1;
      end
    end
  end

  // ---- output FIFO ----
  assign out_valid = (cnt != '0);
  assign full      = (cnt == CW'(FIFO_DEPTH));
  assign pop       = out_valid & out_ready;
  assign wr        = push & (~full | pop);
  assign drop      = push & full & ~pop;
  assign rem       = cnt - CW'(pop);
  assign rptr_n    = rptr + AW'(pop);

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= {ch, byte_n};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr) wptr <= wptr + AW'(1);
      rptr <= rptr_n;
      cnt  <= cnt + CW'(wr) - CW'(pop);
    end
  end

  // Registered head copy: holds its last value once the FIFO drains,
  // and a push into an empty FIFO bypasses memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
    end else if (rem == '0) begin
      if (wr) head <= {ch, byte_n};
    end else begin
      head <= mem[rptr_n];
    end
  end

  assign out_ch   = head[12:8];
  assign out_data = head[7:0];
  assign fifo_cnt = cnt;

  // ---- sticky flags: a set in the clear cycle wins ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf     <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      if (drop)         ovf <= 1'b1;
      else if (err_clr) ovf <= 1'b0;
      if (misfs)        frm_err <= 1'b1;
      else if (err_clr) frm_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tdm_serial_in.sv
// Directed self-checking bench for tdm_serial_in
// (NUM_CH=32, FIFO_DEPTH=4).
module tb_tdm_serial_in;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bit_en = 1'b0;
  logic       fs = 1'b0;
  logic       sdi = 1'b0;
  logic       out_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic [4:0] out_ch;
  logic [2:0] fifo_cnt;
  logic       ovf;
  logic       frm_err;

  int checks = 0;
  int errors = 0;

  tdm_serial_in #(.NUM_CH(32), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .bit_en(bit_en),
    .fs(fs),
    .sdi(sdi),
    .out_ready(out_ready),
    .err_clr(err_clr),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ch(out_ch),
    .fifo_cnt(fifo_cnt),
    .ovf(ovf),
    .frm_err(frm_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(logic f, logic b);
    @(negedge clk);
    bit_en = 1'b1;
    fs     = f;
    sdi    = b;
    @(negedge clk);
    bit_en = 1'b0;
    fs     = 1'b0;
  endtask

  task automatic send_byte(logic f, logic [7:0] d);
    for (int k = 7; k >= 0; k--)
      send_bit(f && (k == 7), d[k]);
  endtask

  task automatic pop_chk(string tag, logic [4:0] c, logic [7:0] d);
    chk({tag, "_v"}, 32'(out_valid), 32'd1);
    chk({tag, "_ch"}, 32'(out_ch), 32'(c));
    chk({tag, "_d"}, 32'(out_data), 32'(d));
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  logic [7:0] v;

  initial begin
    // reset values
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_cnt", 32'(fifo_cnt), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_ch", 32'(out_ch), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_frm", 32'(frm_err), 32'd0);
    reset = 1'b0;

    // unsynchronised: data ignored
    send_byte(1'b0, 8'hFF);
    chk("unsync_cnt", 32'(fifo_cnt), 32'd0);

    // two channels, held then drained
    send_byte(1'b1, 8'hA5);
    chk("a5_cnt", 32'(fifo_cnt), 32'd1);
    send_byte(1'b0, 8'h3C);
    chk("3c_cnt", 32'(fifo_cnt), 32'd2);
    repeat (3) @(negedge clk);
    pop_chk("p0", 5'd0, 8'hA5);
    pop_chk("p1", 5'd1, 8'h3C);
    chk("drained_v", 32'(out_valid), 32'd0);
    chk("hold_data", 32'(out_data), 32'h3C);
    chk("hold_ch", 32'(out_ch), 32'd1);
    chk("frm_ok", 32'(frm_err), 32'd0);

    // fs at bit 3 of channel 2
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    chk("mis_frm", 32'(frm_err), 32'd1);
    chk("mis_cnt", 32'(fifo_cnt), 32'd0);
    for (int k = 6; k >= 0; k--) begin
      v = 8'h5A;
      send_bit(1'b0, v[k]);
    end
    chk("mis_cnt2", 32'(fifo_cnt), 32'd1);
    pop_chk("mis", 5'd0, 8'h5A);
    pulse_clr();
    chk("frm_clr", 32'(frm_err), 32'd0);

    // overflow: five bytes, depth four
    send_byte(1'b0, 8'h11);
    send_byte(1'b0, 8'h22);
    send_byte(1'b0, 8'h33);
    send_byte(1'b0, 8'h44);
    chk("full_ovf0", 32'(ovf), 32'd0);
    send_byte(1'b0, 8'h55);
    chk("ovf_cnt", 32'(fifo_cnt), 32'd4);
    chk("ovf_flag", 32'(ovf), 32'd1);
    pop_chk("o1", 5'd1, 8'h11);
    pop_chk("o2", 5'd2, 8'h22);
    pop_chk("o3", 5'd3, 8'h33);
    pop_chk("o4", 5'd4, 8'h44);
    chk("ovf_empty", 32'(out_valid), 32'd0);
    pulse_clr();
    chk("ovf_clr", 32'(ovf), 32'd0);

    // full FIFO, push coincides with pop
    send_byte(1'b0, 8'h61);
    send_byte(1'b0, 8'h62);
    send_byte(1'b0, 8'h63);
    send_byte(1'b0, 8'h64);
    chk("sp_full", 32'(fifo_cnt), 32'd4);
    for (int k = 7; k >= 1; k--) begin
      v = 8'h65;
      send_bit(1'b0, v[k]);
    end
    @(negedge clk);
    bit_en    = 1'b1;
    sdi       = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    bit_en    = 1'b0;
    out_ready = 1'b0;
    chk("sp_cnt", 32'(fifo_cnt), 32'd4);
    chk("sp_ovf", 32'(ovf), 32'd0);
    pop_chk("s1", 5'd7, 8'h62);
    pop_chk("s2", 5'd8, 8'h63);
    pop_chk("s3", 5'd9, 8'h64);
    pop_chk("s4", 5'd10, 8'h65);

    // reset mid-byte with two buffered
    send_byte(1'b0, 8'h81);
    send_byte(1'b0, 8'h82);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    chk("pre_rst_cnt", 32'(fifo_cnt), 32'd2);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_cnt", 32'(fifo_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    send_byte(1'b0, 8'h77);
    chk("mr_nofs", 32'(fifo_cnt), 32'd0);

    // full frame plus one, no further fs, immediate drain
    out_ready = 1'b1;
    send_byte(1'b1, 8'hC3);
    chk("w0_v", 32'(out_valid), 32'd1);
    chk("w0_ch", 32'(out_ch), 32'd0);
    chk("w0_d", 32'(out_data), 32'hC3);
    for (int i = 1; i <= 32; i++) begin
      v = 8'(i * 7 + 1);
      send_byte(1'b0, v);
      chk($sformatf("w%0d_ch", i), 32'(out_ch), 32'(i % 32));
      chk($sformatf("w%0d_d", i), 32'(out_data), 32'(v));
    end
    chk("w_frm", 32'(frm_err), 32'd0);
    chk("w_ovf", 32'(ovf), 32'd0);
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_serial_in.md
TDM_SERIAL_IN -- requirements
Module: tdm_serial_in

Interface
REQ-001 Parameter NUM_CH, default 32: PCM channels per TDM frame; legal values are 2 to 32.
REQ-002 Parameter FIFO_DEPTH, default 4: depth of the output sample FIFO; must be a power of 2 and at least 2.
REQ-003 Port list SHALL be as follows, with clock and reset first.
- clk  input  1  single system clock; all logic is rising-edge triggered.
- reset  input  1  asynchronous, active-high reset.
- bit_en  input  1  one-cycle strobe marking a valid serial bit on sdi.
- fs  input  1  frame sync; qualified by bit_en; high marks the MSB of channel 0.
- sdi  input  1  serial PCM data, MSB first; qualified by bit_en.
- out_ready  input  1  downstream codec core accepts the head sample.
- err_clr  input  1  one-cycle pulse that clears the sticky error flags.
- out_valid  output  1  FIFO is non-empty; the head sample is presented.
- out_data  output  8  PCM byte at the FIFO head.
- out_ch  output  5  channel number of out_data.
- fifo_cnt  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- ovf  output  1  sticky flag: a sample was dropped because the FIFO was full.
- frm_err  output  1  sticky flag: fs arrived at a position other than a byte boundary of channel 0.

Function
REQ-004 All state SHALL advance only on bit_en=1 cycles, except FIFO pop and err_clr, which act on any cycle.
REQ-005 The block SHALL start unsynchronised and ignore sdi until the first bit_en cycle with fs=1.
REQ-006 A bit_en cycle with fs=1 SHALL take that sdi bit as bit 7 of channel 0 and set bit index to 1 and channel to 0.
REQ-007 The shifter SHALL collect bits MSB first; the 8th bit_en bit SHALL complete the byte.
REQ-008 On the clock edge sampling the 8th bit, the block SHALL push {channel, byte} into the FIFO.
- out_valid SHALL be high in the following cycle if the FIFO was empty.
REQ-009 After the last channel (NUM_CH-1) completes, the channel counter SHALL wrap to 0.
- This wrap needs no fs; the block free-runs once synchronised.
REQ-010 fs=1 at bit index 0 of channel 0 (the expected position) SHALL be accepted silently.
REQ-011 fs=1 at any other position SHALL discard the partial byte and resynchronise per REQ-006.
- It SHALL also set frm_err and push no sample for the discarded byte.
REQ-012 FIFO pop SHALL occur on any cycle where out_valid=1 and out_ready=1.
- The next entry SHALL be presented in the following cycle.
REQ-013 out_data and out_ch SHALL hold the head entry stable while out_valid=1 and out_ready=0.
REQ-014 A push while the FIFO is full without a simultaneous pop SHALL drop the new sample, set ovf, and leave FIFO contents unchanged.
REQ-015 Simultaneous push and pop when full SHALL both occur, with no overflow.
REQ-016 Simultaneous push and pop when empty SHALL perform the push only; out_valid SHALL not be high in the push cycle.
REQ-017 fifo_cnt SHALL equal pushes minus pops at all times, with range 0 to FIFO_DEPTH.
REQ-018 err_clr SHALL clear ovf and frm_err.
- If a set event occurs in the same cycle as err_clr, the flag SHALL end set.
REQ-019 When out_valid=0, out_data and out_ch SHALL hold their last value.

Reset
REQ-020 While reset=1 the block SHALL drive the following reset values:
- out_valid=0, out_data=0, out_ch=0, fifo_cnt=0, ovf=0, frm_err=0.
- FIFO empty, shifter=0, bit index=0, channel=0, unsynchronised.
REQ-021 Reset asserted mid-byte or mid-frame SHALL discard all partial and buffered data.
- After reset the block SHALL wait for a new fs before collecting data.

Verification
REQ-022 Scenario: fs on the first bit, then sdi bytes 0xA5 (channel 0) and 0x3C (channel 1), out_ready=1 -> two outputs, out_ch=0/out_data=0xA5 then out_ch=1/out_data=0x3C, frm_err=0.
REQ-023 Scenario: NUM_CH=32, fs only at the first frame, 33 bytes sent -> the 33rd output has out_ch=0; out_ch sequence is 0..31,0.
REQ-024 Scenario: out_ready=0, 5 bytes sent, FIFO_DEPTH=4 -> fifo_cnt=4, ovf=1, and draining returns bytes 1-4 with the 5th absent.
REQ-025 Scenario: fs asserted at bit 3 of channel 2 -> frm_err=1, no sample emitted for channel 2, next byte tagged out_ch=0.
REQ-026 Scenario: FIFO full with out_ready=1, and the 8th bit arriving in the same cycle as a pop -> fifo_cnt stays 4, ovf=0.
REQ-027 Scenario: reset pulsed mid-byte with 2 samples buffered -> out_valid=0 and fifo_cnt=0 immediately; no output until the next fs.
